cdb_arbiter: RTL and testbench

//  Producer end of the common data bus (CDB) that the issue queues snoop. Collects completed results
//  (tag, data) from N_SRC execution units, buffers each source in a small FIFO, picks one winner per

---
 rtl/cdb_pkg.sv | 13 +
 rtl/cdb_src_fifo.sv | 67 ++++++
 rtl/cdb_arbiter.sv | 114 +++++++++++
 tb/tb_cdb_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_pkg.sv
// Shared types for the common data bus: a broadcast entry is a destination
// tag plus its result data. Issue queues and the ROB use the same entry type.
package cdb_pkg;

    localparam int TAG_W  = 6;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } cdb_entry_t;

endpackage

// File: rtl/cdb_src_fifo.sv
// Small per-source result FIFO. Head is visible combinationally so the
// arbiter can register it straight onto the bus. Flush clears occupancy and
// pointers and overrides any push or pop in the same cycle.
module cdb_src_fifo
    import cdb_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       push,
    input  logic       pop,
    input  cdb_entry_t push_entry,
    output cdb_entry_t head,
    output logic       full,
    output logic       empty
);

    cdb_entry_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;
    assign head    = mem[rd_ptr_reg];

    // Entry storage: written on accepted push only, no reset needed
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_entry;
        end
    end

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB producer: buffers results from N_SRC execution units in per-source
// FIFOs, picks one non-empty source per cycle round-robin and drives the
// registered broadcast. Tag/data widths come from cdb_pkg so the entry type
// stays identical to the one the queues and ROB consume.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int N_SRC = 4,
    parameter int DEPTH = 2,
    localparam int IDX_W = $clog2(N_SRC),
    localparam int DBL_W = $clog2(2 * N_SRC)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [N_SRC-1:0]          res_valid,
    input  logic [N_SRC*TAG_W-1:0]    res_tag,
    input  logic [N_SRC*DATA_W-1:0]   res_data,
    output logic [N_SRC-1:0]          res_ready,
    output logic                      cdb_valid,
    output logic [TAG_W-1:0]          cdb_tag,
    output logic [DATA_W-1:0]         cdb_data,
    output logic [IDX_W-1:0]          cdb_src
);

    logic [N_SRC-1:0]   req;
    logic [N_SRC-1:0]   full;
    logic [N_SRC-1:0]   empty;
    logic [N_SRC-1:0]   push;
    logic [N_SRC-1:0]   pop;
    cdb_entry_t         fifo_head [N_SRC];
    logic [IDX_W-1:0]   rr_ptr_reg;
    logic [2*N_SRC-1:0] req_dbl;
    logic [DBL_W-1:0]   scan_idx;
    logic [IDX_W-1:0]   grant_off;
    logic [IDX_W:0]     win_sum;
    logic [IDX_W-1:0]   winner;
    logic               any_req;
    cdb_entry_t         win_entry;

    genvar gi;
    generate
        for (gi = 0; gi < N_SRC; gi++) begin : g_src
            cdb_entry_t push_entry;

            // Ready depends only on occupancy, never on the grant (no bypass)
            assign push_entry    = {res_tag[gi*TAG_W +: TAG_W], res_data[gi*DATA_W +: DATA_W]};
            assign res_ready[gi] = ~full[gi];
            assign req[gi]       = ~empty[gi];
            assign push[gi]      = res_valid[gi] & res_ready[gi];
            assign pop[gi]       = any_req && (winner == IDX_W'(gi));

            cdb_src_fifo #(
                .DEPTH (DEPTH)
            ) u_fifo (
                .clk        (clk),
                .rst        (rst),
                .flush      (flush),
                .push       (push[gi]),
                .pop        (pop[gi]),
                .push_entry (push_entry),
                .head       (fifo_head[gi]),
                .full       (full[gi]),
                .empty      (empty[gi])
            );
        end
    endgenerate

    // Round-robin grant: scan the doubled request vector from rr_ptr, first hit wins
    always_comb begin
        any_req   = |req;
        req_dbl   = {req, req};
        scan_idx  = '0;
        grant_off = '0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            scan_idx = DBL_W'(rr_ptr_reg) + DBL_W'(k);
            if (req_dbl[scan_idx]) begin
                grant_off = IDX_W'(k);
            end
        end
        win_sum = {1'b0, rr_ptr_reg} + {1'b0, grant_off};
        if (win_sum >= (IDX_W + 1)'(N_SRC)) begin
            win_sum = win_sum - (IDX_W + 1)'(N_SRC);
        end
        winner    = win_sum[IDX_W-1:0];
        win_entry = fifo_head[winner];
    end

    // Registered broadcast and pointer advance; flush squashes the bus but keeps rr_ptr
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_reg <= '0;
            cdb_valid  <= 1'b0;
            cdb_tag    <= '0;
            cdb_data   <= '0;
            cdb_src    <= '0;
        end else if (flush) begin
            cdb_valid  <= 1'b0;
            cdb_tag    <= '0;
            cdb_data   <= '0;
        end else if (any_req) begin
            rr_ptr_reg <= (winner == IDX_W'(N_SRC - 1)) ? '0 : winner + 1'b1;
            cdb_valid  <= 1'b1;
            cdb_tag    <= win_entry.tag;
            cdb_data   <= win_entry.data;
            cdb_src    <= winner;
        end else begin
            cdb_valid  <= 1'b0;
            cdb_tag    <= '0;
            cdb_data   <= '0;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed and soak bench for the CDB arbiter (N_SRC=4, DEPTH=2).
// Inputs change on the falling edge; outputs are sampled there too.
module tb_cdb_arbiter;
    import cdb_pkg::*;

    localparam int N_SRC = 4;
    localparam int DEPTH = 2;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic                    flush = 1'b0;
    logic [N_SRC-1:0]        res_valid = 4'hF;
    logic [N_SRC*TAG_W-1:0]  res_tag = '1;
    logic [N_SRC*DATA_W-1:0] res_data = '1;
    logic [N_SRC-1:0]        res_ready;
    logic                    cdb_valid;
    logic [TAG_W-1:0]        cdb_tag;
    logic [DATA_W-1:0]       cdb_data;
    logic [1:0]              cdb_src;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    cdb_arbiter #(
        .N_SRC (N_SRC),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .res_valid (res_valid),
        .res_tag   (res_tag),
        .res_data  (res_data),
        .res_ready (res_ready),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data),
        .cdb_src   (cdb_src)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_src(input int i, input logic v, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
        res_valid[i] = v;
        res_tag[i*TAG_W +: TAG_W] = t;
        res_data[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic expect_cdb(input string name, input int src, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
        check({name, ".valid"}, cdb_valid, 1);
        check({name, ".src"}, cdb_src, src);
        check({name, ".tag"}, cdb_tag, t);
        check({name, ".data"}, cdb_data, d);
        $display("cdb %s: src=%0d tag=%h data=%h", name, cdb_src, cdb_tag, cdb_data);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        flush = 1'b0;
        res_valid = '0;
        step();
        rst = 1'b1;
    endtask

    cdb_entry_t exp_q [N_SRC][$];
    int         acc_q [N_SRC][$];
    int         log_src [$];
    int         log_tag [$];

    initial begin
        int a_sent, b_sent, ai, bi, s, a, total;
        logic xa, xb, exp_v;
        logic [N_SRC-1:0] exp_ready;
        cdb_entry_t e;

        // Reset held with all sources offering
        repeat (3) step();
        check("rst.valid", cdb_valid, 0);
        check("rst.tag", cdb_tag, 0);
        check("rst.data", cdb_data, 0);
        check("rst.src", cdb_src, 0);
        res_valid = '0;
        rst = 1'b1;
        step();
        check("rst.ready", res_ready, 4'hF);
        check("rst.nofill", cdb_valid, 0);
        step();
        check("rst.nofill2", cdb_valid, 0);

        // Single result from src2
        set_src(2, 1'b1, 6'h15, 32'hDEADBEEF);
        step();
        res_valid = '0;
        check("single.lat", cdb_valid, 0);
        step();
        expect_cdb("single", 2, 6'h15, 32'hDEADBEEF);
        step();
        check("single.after_v", cdb_valid, 0);
        check("single.after_t", cdb_tag, 0);

        // Round robin from rr_ptr=0
        do_reset();
        for (int i = 0; i < N_SRC; i++) set_src(i, 1'b1, 6'h10 + 6'(i), 32'hA000_0000 + i);
        step();
        res_valid = '0;
        step();
        for (int j = 0; j < N_SRC; j++) begin
            expect_cdb("rr0", j, 6'h10 + 6'(j), 32'hA000_0000 + j);
            step();
        end
        check("rr0.idle", cdb_valid, 0);
        // src1 alone moves rr_ptr to 2
        set_src(1, 1'b1, 6'h21, 32'h0000_0021);
        step();
        res_valid = '0;
        step();
        expect_cdb("rr_mv", 1, 6'h21, 32'h0000_0021);
        for (int i = 0; i < N_SRC; i++) set_src(i, 1'b1, 6'h18 + 6'(i), 32'hB000_0000 + i);
        step();
        res_valid = '0;
        step();
        for (int j = 0; j < N_SRC; j++) begin
            s = (2 + j) % N_SRC;
            expect_cdb("rr2", s, 6'h18 + 6'(s), 32'hB000_0000 + s);
            step();
        end

        // Back-pressure: src0 floods, src1 sends three back-to-back
        do_reset();
        a_sent = 0;
        b_sent = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (cdb_valid) begin
                log_src.push_back(int'(cdb_src));
                log_tag.push_back(int'(cdb_tag));
            end
            if (cyc == 2) begin
                check("bp.ready1_full", res_ready[1], 0);
                check("bp.first", {cdb_src, cdb_tag}, {2'd0, 6'h00});
            end
            if (cyc == 3) begin
                check("bp.held", b_sent, 2);
                check("bp.ready1_again", res_ready[1], 1);
                check("bp.second", {cdb_src, cdb_tag}, {2'd1, 6'h30});
            end
            if (cyc == 4) begin
                check("bp.third", {cdb_src, cdb_tag}, {2'd0, 6'h01});
            end
            set_src(0, cyc < 6, 6'(a_sent), 32'h0A00_0000 + a_sent);
            set_src(1, b_sent < 3, 6'h30 + 6'(b_sent), 32'h0B00_0000 + b_sent);
            xa = res_valid[0] & res_ready[0];
            xb = res_valid[1] & res_ready[1];
            step();
            if (xa) a_sent++;
            if (xb) b_sent++;
        end
        res_valid = '0;
        ai = 0;
        bi = 0;
        foreach (log_src[k]) begin
            if (log_src[k] == 1) begin
                check("bp.src1_order", log_tag[k], 6'h30 + bi);
                bi++;
            end else begin
                check("bp.src0_order", log_tag[k], ai);
                ai++;
            end
        end
        check("bp.src1_count", bi, 3);
        check("bp.total", log_src.size(), a_sent + 3);

        // Flush with five results buffered
        do_reset();
        for (int i = 0; i < N_SRC; i++) set_src(i, 1'b1, 6'h08 + 6'(i), 32'hC000_0000 + i);
        step();
        res_valid = '0;
        set_src(0, 1'b1, 6'h0C, 32'hC000_000C);
        set_src(1, 1'b1, 6'h0D, 32'hC000_000D);
        step();
        res_valid = '0;
        expect_cdb("fl.pre", 0, 6'h08, 32'hC000_0000);
        check("fl.ready_pre", res_ready, 4'b1101);
        flush = 1'b1;
        set_src(3, 1'b1, 6'h3F, 32'hFFFF_FFFF);
        step();
        flush = 1'b0;
        res_valid = '0;
        check("fl.valid", cdb_valid, 0);
        check("fl.ready", res_ready, 4'hF);
        for (int j = 0; j < 6; j++) begin
            step();
            check("fl.silent", cdb_valid, 0);
        end
        // rr_ptr held at 1 across the flush
        for (int i = 0; i < N_SRC; i++) set_src(i, 1'b1, 6'h20 + 6'(i), 32'hD000_0000 + i);
        step();
        res_valid = '0;
        step();
        expect_cdb("fl.rr_held", 1, 6'h21, 32'hD000_0001);

        // Asynchronous reset mid-operation with results still buffered
        #2 rst = 1'b0;
        #1;
        check("arst.valid", cdb_valid, 0);
        check("arst.tag_data", {cdb_tag, cdb_data}, 0);
        check("arst.src", cdb_src, 0);
        @(negedge clk);
        rst = 1'b1;
        step();
        check("arst.discard", cdb_valid, 0);

        // Random soak against a per-source scoreboard
        do_reset();
        exp_v = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            check("soak.valid", cdb_valid, exp_v);
            if (cdb_valid) begin
                s = int'(cdb_src);
                check("soak.nonempty", exp_q[s].size() != 0, 1);
                if (exp_q[s].size() != 0) begin
                    e = exp_q[s].pop_front();
                    a = acc_q[s].pop_front();
                    check("soak.entry", {cdb_tag, cdb_data}, e);
                    check("soak.wait", (cyc - a) <= N_SRC * DEPTH, 1);
                end
            end
            exp_ready = '0;
            exp_v = 1'b0;
            for (int i = 0; i < N_SRC; i++) begin
                exp_ready[i] = (exp_q[i].size() != DEPTH);
                if (exp_q[i].size() != 0) exp_v = 1'b1;
            end
            check("soak.ready", res_ready, exp_ready);
            for (int i = 0; i < N_SRC; i++) begin
                set_src(i, (cyc < 360) && ($urandom_range(0, 9) < 6), 6'($urandom), $urandom);
                if (res_valid[i] && exp_ready[i]) begin
                    exp_q[i].push_back({res_tag[i*TAG_W +: TAG_W], res_data[i*DATA_W +: DATA_W]});
                    acc_q[i].push_back(cyc + 1);
                end
            end
            step();
        end
        total = 0;
        for (int i = 0; i < N_SRC; i++) total += exp_q[i].size();
        check("soak.drained", total, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
